// File: rtl/id_scoreboard_pkg.sv
// Shared sizing for the ID-stage register-write scoreboard.
package id_scoreboard_pkg;
    localparam int SB_NREG   = 32;
    localparam int SB_CNT_W  = 2;
    localparam int SB_PERF_W = 32;
endpackage

// File: rtl/id_scoreboard_sb_counter.sv
// Per-register outstanding-write counter: saturating up/down with synchronous clear.
module sb_counter
    import id_scoreboard_pkg::*;
#(
    parameter int CNT_W = SB_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             sat,
    output logic             underflow
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cnt       = cnt_q;
    assign sat       = (cnt_q == '1);
    // A retire that meets an empty counter is a protocol error; same-cycle issue cancels it.
    assign underflow = !clr && dec && !inc && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !dec) begin
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end else if (dec && !inc) begin
            if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/id_scoreboard.sv
// ID-stage scoreboard: tracks in-flight GPR writes and gates ds_ready_go on RAW hazards.
module id_scoreboard
    import id_scoreboard_pkg::*;
#(
    parameter int NREG   = SB_NREG,
    parameter int CNT_W  = SB_CNT_W,
    parameter int PERF_W = SB_PERF_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              ds_valid,
    input  logic              es_allowin,
    input  logic [4:0]        ds_rs1,
    input  logic [4:0]        ds_rs2,
    input  logic              ds_use_rs1,
    input  logic              ds_use_rs2,
    input  logic              ds_gr_we,
    input  logic [4:0]        ds_dest,
    input  logic              ws_rf_we,
    input  logic [4:0]        ws_rf_waddr,
    output logic              ds_ready_go,
    output logic [NREG-1:0]   busy_vec,
    output logic [PERF_W-1:0] stall_cnt,
    output logic              err_underflow
);
    logic [NREG-1:0]   sat_vec;
    logic [NREG-1:0]   uf_vec;
    logic              issue, retire, raw_haz, sat_hit;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
    logic              err_q, err_d;

    assign busy_vec[0] = 1'b0;
    assign sat_vec[0]  = 1'b0;
    assign uf_vec[0]   = 1'b0;

    for (genvar i = 1; i < NREG; i++) begin : g_cnt
        logic [CNT_W-1:0] cnt_i;
        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .clr       (flush),
            .inc       (issue  && (ds_dest     == 5'(i))),
            .dec       (retire && (ws_rf_waddr == 5'(i))),
            .cnt       (cnt_i),
            .sat       (sat_vec[i]),
            .underflow (uf_vec[i])
        );
        assign busy_vec[i] = (cnt_i != '0);
    end

    // No regfile bypass: a source retiring this cycle still reads busy.
    assign raw_haz     = (ds_use_rs1 && busy_vec[ds_rs1]) || (ds_use_rs2 && busy_vec[ds_rs2]);
    assign sat_hit     = ds_gr_we && (ds_dest != '0) && sat_vec[ds_dest];
    assign ds_ready_go = !(raw_haz || sat_hit);

    assign issue  = ds_valid && ds_ready_go && es_allowin && ds_gr_we && (ds_dest != '0);
    assign retire = ws_rf_we && (ws_rf_waddr != '0);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        err_d       = err_q;
        if (ds_valid && !ds_ready_go) stall_cnt_d = stall_cnt_q + PERF_W'(1);
        if (|uf_vec) err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
        end
    end

    assign stall_cnt     = stall_cnt_q;
    assign err_underflow = err_q;
endmodule

// File: tb/tb_id_scoreboard.sv
// Randomized and directed checks of id_scoreboard against a counting reference model.
module tb_id_scoreboard;
    logic        clk = 1'b0;
    logic        reset, flush, ds_valid, es_allowin;
    logic [4:0]  ds_rs1, ds_rs2, ds_dest, ws_rf_waddr;
    logic        ds_use_rs1, ds_use_rs2, ds_gr_we, ws_rf_we;
    logic        ds_ready_go, err_underflow;
    logic [31:0] busy_vec, stall_cnt;

    int          checks = 0;
    int          failures = 0;
    bit          cmp_en = 1'b0;

    int          mcnt [32];
    logic [31:0] mstall;
    bit          merr;
    bit          m_rdy, m_iss, m_ret;

    always #5 clk = ~clk;

    id_scoreboard #(.NREG(32), .CNT_W(2), .PERF_W(32)) dut (
        .clk(clk), .reset(reset), .flush(flush), .ds_valid(ds_valid), .es_allowin(es_allowin),
        .ds_rs1(ds_rs1), .ds_rs2(ds_rs2), .ds_use_rs1(ds_use_rs1), .ds_use_rs2(ds_use_rs2),
        .ds_gr_we(ds_gr_we), .ds_dest(ds_dest), .ws_rf_we(ws_rf_we), .ws_rf_waddr(ws_rf_waddr),
        .ds_ready_go(ds_ready_go), .busy_vec(busy_vec), .stall_cnt(stall_cnt),
        .err_underflow(err_underflow)
    );

    function automatic logic exp_ready();
        logic haz, st;
        haz = (ds_use_rs1 && ds_rs1 != 0 && mcnt[ds_rs1] != 0) ||
              (ds_use_rs2 && ds_rs2 != 0 && mcnt[ds_rs2] != 0);
        st  = ds_gr_we && ds_dest != 0 && mcnt[ds_dest] == 3;
        return !(haz || st);
    endfunction

    function automatic logic [31:0] exp_busy();
        logic [31:0] b = '0;
        for (int i = 1; i < 32; i++) b[i] = (mcnt[i] != 0);
        return b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-register outstanding-write counts.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mcnt[i] = 0;
            mstall = '0;
            merr   = 1'b0;
        end else begin
            m_rdy = exp_ready();
            if (ds_valid && !m_rdy) mstall = mstall + 1;
            if (flush) begin
                for (int i = 0; i < 32; i++) mcnt[i] = 0;
            end else begin
                m_iss = ds_valid && m_rdy && es_allowin && ds_gr_we && ds_dest != 0;
                m_ret = ws_rf_we && ws_rf_waddr != 0;
                if (!(m_iss && m_ret && ds_dest == ws_rf_waddr)) begin
                    if (m_iss) mcnt[ds_dest] = mcnt[ds_dest] + 1;
                    if (m_ret) begin
                        if (mcnt[ws_rf_waddr] == 0) merr = 1'b1;
                        else mcnt[ws_rf_waddr] = mcnt[ws_rf_waddr] - 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy_vec", busy_vec, exp_busy());
            chk("ds_ready_go", ds_ready_go, exp_ready());
            chk("stall_cnt", stall_cnt, mstall);
            chk("err_underflow", err_underflow, merr);
        end
    end

    task automatic go(input logic v, input logic a, input logic [4:0] r1, input logic u1,
                      input logic we, input logic [4:0] d, input logic rwe,
                      input logic [4:0] wa, input logic fl);
        @(posedge clk); #1;
        ds_valid = v; es_allowin = a; ds_rs1 = r1; ds_use_rs1 = u1;
        ds_rs2 = '0; ds_use_rs2 = 1'b0; ds_gr_we = we; ds_dest = d;
        ws_rf_we = rwe; ws_rf_waddr = wa; flush = fl;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        ds_valid = 0; es_allowin = 0; ds_rs1 = 0; ds_use_rs1 = 0; ds_rs2 = 0; ds_use_rs2 = 0;
        ds_gr_we = 0; ds_dest = 0; ws_rf_we = 0; ws_rf_waddr = 0; flush = 0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 0; ds_valid = 0; es_allowin = 0; ds_rs1 = 0; ds_rs2 = 0;
        ds_use_rs1 = 0; ds_use_rs2 = 0; ds_gr_we = 0; ds_dest = 0; ws_rf_we = 0; ws_rf_waddr = 0;
        #1 cmp_en = 1'b1;

        // 1: reset state, then an issue to x5 shows busy the next cycle
        do_reset();
        go(0,0, 0,0, 0,0, 0,0, 0);
        chk("t1_busy_reset", busy_vec, 32'h0);
        chk("t1_ready_reset", ds_ready_go, 1'b1);
        chk("t1_stall_reset", stall_cnt, 32'd0);
        go(1,1, 0,0, 1,5, 0,0, 0);
        chk("t1_busy_same_cycle", busy_vec, 32'h0);
        go(0,0, 0,0, 0,0, 0,0, 0);
        chk("t1_busy_x5", busy_vec, 32'h0000_0020);

        // 2: RAW on x5, retire three cycles after issue
        do_reset();
        go(1,1, 0,0, 1,5, 0,0, 0);
        go(1,1, 5,1, 0,0, 0,0, 0);
        chk("t2_raw_stall", ds_ready_go, 1'b0);
        go(1,1, 5,1, 0,0, 0,0, 0);
        go(1,1, 5,1, 0,0, 1,5, 0);
        chk("t2_no_bypass", ds_ready_go, 1'b0);
        go(1,1, 5,1, 0,0, 0,0, 0);
        chk("t2_ready_after_retire", ds_ready_go, 1'b1);
        chk("t2_stall_cnt", stall_cnt, 32'd3);

        // 3: same-register issue and retire leaves the count unchanged
        do_reset();
        go(1,1, 0,0, 1,7, 0,0, 0);
        go(1,1, 0,0, 1,7, 1,7, 0);
        chk("t3_busy7_before", busy_vec[7], 1'b1);
        go(0,0, 0,0, 0,0, 0,0, 0);
        chk("t3_busy7_kept", busy_vec[7], 1'b1);
        go(0,0, 0,0, 0,0, 1,7, 0);
        go(0,0, 0,0, 0,0, 0,0, 0);
        chk("t3_busy7_cleared", busy_vec, 32'h0);

        // 4: saturation of x9 at three outstanding writes
        do_reset();
        go(1,1, 0,0, 1,9, 0,0, 0);
        go(1,1, 0,0, 1,9, 0,0, 0);
        go(1,1, 0,0, 1,9, 0,0, 0);
        go(1,1, 0,0, 1,9, 0,0, 0);
        chk("t4_sat_stall", ds_ready_go, 1'b0);
        go(1,1, 0,0, 1,9, 1,9, 0);
        chk("t4_sat_during_retire", ds_ready_go, 1'b0);
        go(1,1, 0,0, 1,9, 0,0, 0);
        chk("t4_fourth_issues", ds_ready_go, 1'b1);
        go(1,1, 0,0, 1,9, 0,0, 0);
        chk("t4_sat_again", ds_ready_go, 1'b0);
        go(0,0, 0,0, 0,0, 0,0, 0);
        chk("t4_stall_cnt", stall_cnt, 32'd3);

        // 5: x0 is never tracked
        do_reset();
        go(1,1, 0,1, 1,0, 1,0, 0);
        chk("t5_ready_x0", ds_ready_go, 1'b1);
        go(0,0, 0,0, 0,0, 0,0, 0);
        chk("t5_busy_x0", busy_vec, 32'h0);
        chk("t5_err_x0", err_underflow, 1'b0);
        chk("t5_stall_x0", stall_cnt, 32'd0);

        // 6: underflow is sticky, flush clears tracking, reset is immediate
        do_reset();
        go(0,0, 0,0, 0,0, 1,3, 0);
        go(1,1, 0,0, 1,4, 0,0, 0);
        chk("t6_err_set", err_underflow, 1'b1);
        go(0,0, 0,0, 0,0, 0,0, 1);
        chk("t6_busy_before_flush", busy_vec, 32'h0000_0010);
        go(0,0, 0,0, 0,0, 0,0, 0);
        chk("t6_busy_flushed", busy_vec, 32'h0);
        chk("t6_err_kept", err_underflow, 1'b1);
        go(1,1, 0,0, 1,5, 0,0, 0);
        go(1,1, 5,1, 0,0, 0,0, 0);
        go(1,1, 5,1, 0,0, 0,0, 0);
        chk("t6_stalling", ds_ready_go, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_busy", busy_vec, 32'h0);
        chk("t6_rst_ready", ds_ready_go, 1'b1);
        chk("t6_rst_stall", stall_cnt, 32'd0);
        chk("t6_rst_err", err_underflow, 1'b0);
        @(posedge clk); #1 reset = 1'b0;

        // Random traffic; retires only target registers with outstanding writes
        for (int n = 0; n < 3000; n++) begin
            int r;
            @(posedge clk); #1;
            ds_valid   = ($urandom_range(3) != 0);
            es_allowin = ($urandom_range(3) != 0);
            ds_rs1     = 5'($urandom_range(7));
            ds_use_rs1 = 1'($urandom_range(1));
            ds_rs2     = 5'($urandom_range(7));
            ds_use_rs2 = 1'($urandom_range(1));
            ds_gr_we   = 1'($urandom_range(1));
            ds_dest    = 5'($urandom_range(7));
            r          = int'($urandom_range(7));
            ws_rf_waddr = 5'(r);
            ws_rf_we   = (r == 0) ? ($urandom_range(7) == 0)
                                  : (mcnt[r] > 0 && $urandom_range(1) == 1);
            flush      = ($urandom_range(63) == 0);
        end
        @(posedge clk); #1;
        ds_valid = 0; ws_rf_we = 0; flush = 0;
        @(negedge clk);
        chk("rand_no_underflow", err_underflow, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
